// File: rtl/axis_crc32_mpeg2_checker.sv
// axis_crc32_mpeg2_checker: checks the trailing CRC32/MPEG-2 word of each AXI-Stream frame, strips it, and forwards the payload.
// Optional AXIS_CRC32_CHK_ERR_CNT_EN adds a saturating mismatch counter port crc_err_cnt.
module axis_crc32_mpeg2_checker #(
  parameter int          AXI_DATA_WIDTH = 32,
  parameter logic [31:0] POLY_CRC       = 32'h04C1_1DB7,
  parameter logic [31:0] INIT_CRC       = 32'hFFFF_FFFF
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      crc_done,
  output logic                      crc_match
`ifdef AXIS_CRC32_CHK_ERR_CNT_EN
  ,
  output logic [15:0]               crc_err_cnt
`endif
);
  if (AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("axis_crc32_mpeg2_checker supports only AXI_DATA_WIDTH = 32");
  end
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic run_q, run_d;
  logic [31:0] crc_q, crc_d, hold_q, hold_d, m_data_q, m_data_d, crc_next;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, done_q, done_d, match_q, match_d;
  logic accept, load;
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY_CRC : 32'd0);
    return r;
  endfunction
  // run_q keeps tready low while in reset and rises on the first clock after release
  assign s_axis_tready = run_q && (state_q == IDLE || !m_valid_q || m_axis_tready);
  assign accept = s_axis_tvalid && s_axis_tready;
  assign load = accept && state_q == HOLD;
  assign crc_next = crc_upd(state_q == IDLE ? INIT_CRC : crc_q, s_axis_tdata);
  always_comb begin
    run_d = 1'b1;
    state_d = accept ? (s_axis_tlast ? IDLE : HOLD) : state_q;
    hold_d = (accept && !s_axis_tlast) ? s_axis_tdata : hold_q;
    crc_d = accept ? (s_axis_tlast ? INIT_CRC : crc_next) : crc_q;
    m_valid_d = load || (m_valid_q && !m_axis_tready);
    m_data_d = load ? hold_q : m_data_q;
    m_last_d = load ? s_axis_tlast : m_last_q;
    done_d = accept && s_axis_tlast;
    match_d = done_d ? (s_axis_tdata == (state_q == IDLE ? INIT_CRC : crc_q)) : match_q;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q <= 1'b0;
      state_q <= IDLE;
      hold_q <= '0;
      crc_q <= INIT_CRC;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
      done_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      run_q <= run_d;
      state_q <= state_d;
      hold_q <= hold_d;
      crc_q <= crc_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
      done_q <= done_d;
      match_q <= match_d;
    end
  end
  assign m_axis_tdata = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast = m_last_q;
  assign crc_done = done_q;
  assign crc_match = match_q;
`ifdef AXIS_CRC32_CHK_ERR_CNT_EN
  logic [15:0] err_q, err_d;
  always_comb begin
    err_d = (done_d && !match_d && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_q <= '0;
    else err_q <= err_d;
  end
  assign crc_err_cnt = err_q;
`endif
endmodule

// File: tb/tb_axis_crc32_mpeg2_checker.sv
// tb_axis_crc32_mpeg2_checker: directed bench for the CRC32/MPEG-2 frame checker.
module tb_axis_crc32_mpeg2_checker;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [31:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [31:0] m_data;
  logic m_valid, m_last;
  logic m_ready = 1'b1;
  logic crc_done, crc_match;
`ifdef AXIS_CRC32_CHK_ERR_CNT_EN
  logic [15:0] crc_err_cnt;
`endif
  int checks = 0, errors = 0;
  int done_cnt = 0, good_cnt = 0, stall_cnt = 0;
  bit rnd = 1'b0;
  logic [31:0] got_d[$], exp_d[$];
  logic got_l[$], exp_l[$];
  logic prev_stall = 1'b0, prev_l = 1'b0;
  logic [31:0] prev_d = '0;

  axis_crc32_mpeg2_checker dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .crc_done(crc_done), .crc_match(crc_match)
`ifdef AXIS_CRC32_CHK_ERR_CNT_EN
    , .crc_err_cnt(crc_err_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
      if (crc_done) begin
        done_cnt++;
        if (crc_match) good_cnt++;
      end
      if (s_valid && !s_ready) stall_cnt++;
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", m_data, prev_d);
        chk("stall_last", 32'(m_last), 32'(prev_l));
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end else prev_stall = 1'b0;
  end

  function automatic logic [31:0] model(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      if (r[31] ^ w[i]) r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input logic l, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge aclk); #1; end
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_ready && n < 200);
    if (!s_ready) chk("accept_timeout", 32'(s_ready), 32'd1);
    @(posedge aclk); #1;
    s_valid = 1'b0;
  endtask

  task automatic frame(input logic [31:0] base, input int len, input logic [31:0] flip, input int maxgap);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      c = model(c, base + 32'(i));
      exp_d.push_back(base + 32'(i));
      exp_l.push_back(i == len - 1);
      send(base + 32'(i), 1'b0, int'($urandom_range(0, maxgap)));
    end
    send(c ^ flip, 1'b1, int'($urandom_range(0, maxgap)));
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, 32'(got_d.size()), 32'(exp_d.size()));
    if (got_d.size() == exp_d.size())
      foreach (exp_d[i]) begin
        chk({tag, "_data"}, got_d[i], exp_d[i]);
        chk({tag, "_last"}, 32'(got_l[i]), 32'(exp_l[i]));
      end
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  initial begin
    int d0, g0;
    #3;
    chk("rst_tready", 32'(s_ready), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_mlast", 32'(m_last), 32'd0);
    chk("rst_mdata", m_data, 32'd0);
    chk("rst_done", 32'(crc_done), 32'd0);
    chk("rst_match", 32'(crc_match), 32'd0);
    #12 aresetn = 1'b1;
    settle(2);
    chk("idle_tready", 32'(s_ready), 32'd1);

    d0 = done_cnt;
    send(32'hFFFF_FFFF, 1'b1, 0);
    chk("empty_ok_done", 32'(crc_done), 32'd1);
    chk("empty_ok_match", 32'(crc_match), 32'd1);
    chk("empty_ok_mvalid", 32'(m_valid), 32'd0);
    settle(1);
    chk("empty_ok_pulse", 32'(crc_done), 32'd0);
    chk("empty_ok_match_hold", 32'(crc_match), 32'd1);
    send(32'h0000_0000, 1'b1, 0);
    chk("empty_bad_done", 32'(crc_done), 32'd1);
    chk("empty_bad_match", 32'(crc_match), 32'd0);
    chk("empty_bad_mvalid", 32'(m_valid), 32'd0);
    settle(3);
    chk("empty_done_cnt", 32'(done_cnt - d0), 32'd2);
    got_d.delete(); got_l.delete();

    d0 = done_cnt;
    frame(32'd1, 4, 32'd0, 0);
    chk("good_done", 32'(crc_done), 32'd1);
    chk("good_match", 32'(crc_match), 32'd1);
    chk("good_last_valid", 32'(m_valid), 32'd1);
    chk("good_last_flag", 32'(m_last), 32'd1);
    chk("good_last_data", m_data, 32'd4);
    settle(3);
    chk("good_pulse", 32'(crc_done), 32'd0);
    chk("good_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_out("good");

    frame(32'd1, 4, 32'd1, 0);
    chk("bad_done", 32'(crc_done), 32'd1);
    chk("bad_match", 32'(crc_match), 32'd0);
    settle(3);
    check_out("bad");

    d0 = done_cnt; g0 = good_cnt;
    rnd = 1'b1;
    frame(32'd1, 4, 32'd0, 2);
    settle(40);
    rnd = 1'b0;
    settle(3);
    chk("rand_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("rand_good_cnt", 32'(good_cnt - g0), 32'd1);
    chk("rand_match", 32'(crc_match), 32'd1);
    check_out("rand");

    d0 = done_cnt; g0 = good_cnt; stall_cnt = 0;
    frame(32'h10, 1, 32'd0, 0);
    frame(32'h20, 2, 32'd0, 0);
    frame(32'h30, 5, 32'd0, 0);
    settle(4);
    chk("b2b_stalls", 32'(stall_cnt), 32'd0);
    chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd3);
    chk("b2b_good_cnt", 32'(good_cnt - g0), 32'd3);
    check_out("b2b");

    d0 = done_cnt;
    send(32'd100, 1'b0, 0);
    send(32'd101, 1'b0, 0);
    chk("pre_rst_mvalid", 32'(m_valid), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_tready", 32'(s_ready), 32'd0);
    chk("mid_rst_mvalid", 32'(m_valid), 32'd0);
    chk("mid_rst_mdata", m_data, 32'd0);
    chk("mid_rst_mlast", 32'(m_last), 32'd0);
    chk("mid_rst_done", 32'(crc_done), 32'd0);
    chk("mid_rst_match", 32'(crc_match), 32'd0);
    @(negedge aclk); aresetn = 1'b1;
    settle(2);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    got_d.delete(); got_l.delete();
    frame(32'hA5A5_0000, 5, 32'd0, 0);
    chk("post_rst_done", 32'(crc_done), 32'd1);
    chk("post_rst_match", 32'(crc_match), 32'd1);
    settle(3);
    check_out("post_rst");

    for (int k = 0; k < 3; k++) begin
      frame(32'h55 + 32'(k), 2, 32'h8000_0000, 0);
      chk("errs_match", 32'(crc_match), 32'd0);
    end
    settle(3);
    check_out("errs");
`ifdef AXIS_CRC32_CHK_ERR_CNT_EN
    chk("err_cnt", 32'(crc_err_cnt), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
